// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, register index type and
// the writeback round-robin pointer encoding.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int AW     = 3;

    typedef logic [AW-1:0] reg_idx_t;

    // Which requester currently holds priority when both are valid.
    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_MEM = 1'b1
    } rr_ptr_t;

    // Bit positions of the requesters in valid/grant vectors.
    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;

endpackage

// File: rtl/wb_rr_arb.sv
// Two-way round-robin arbiter for the register-file write port.
// Purely combinational: the caller owns the pointer register and feeds
// ptr_next back into it every cycle.
module wb_rr_arb
    import cpu_pkg::*;
(
    input  logic    [1:0] valid,
    input  rr_ptr_t       ptr,
    input  logic          hold,
    output logic    [1:0] grant,
    output rr_ptr_t       ptr_next
);

    // Grant selection and pointer advance; pointer moves only on a grant.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant    = 2'b00;
        ptr_next = ptr;
        if (!hold) begin
            if (valid[SRC_ALU] && (!valid[SRC_MEM] || ptr == PTR_ALU)) begin
                grant[SRC_ALU] = 1'b1;
            end else if (valid[SRC_MEM]) begin
                grant[SRC_MEM] = 1'b1;
            end
        end
        // Priority passes to the side that was not served.
        if (grant[SRC_ALU]) begin
            ptr_next = PTR_MEM;
        end else if (grant[SRC_MEM]) begin
            ptr_next = PTR_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owner of the single register-file write port. Arbitrates ALU and load
// writebacks, registers the winning write for the register file, tracks
// pending destinations in a busy scoreboard and flags stray writebacks.
module regfile_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [AW-1:0]     alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [AW-1:0]     mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_reg,
    input  logic              wb_hold,
    output logic              rf_write_en,
    output logic [AW-1:0]     rf_wreg,
    output logic [DATA_W-1:0] rf_writedata,
    output logic [NREG-1:0]   busy,
    output logic              wb_err
);

    import cpu_pkg::*;

    rr_ptr_t           ptr_q;
    rr_ptr_t           ptr_next;
    logic [1:0]        grant;
    logic              any_grant;
    logic [AW-1:0]     grant_reg;
    logic [DATA_W-1:0] grant_data;
    logic [NREG-1:0]   busy_next;
    logic              clear_same_reg;
    logic              err_hit;

    wb_rr_arb u_arb (
        .valid    ({mem_valid, alu_valid}),
        .ptr      (ptr_q),
        .hold     (wb_hold),
        .grant    (grant),
        .ptr_next (ptr_next)
    );

    assign alu_ready = grant[SRC_ALU];
    assign mem_ready = grant[SRC_MEM];
    assign any_grant = |grant;

    // Select destination and data of the granted requester.
    always_comb begin
        grant_reg  = alu_reg;
        grant_data = alu_data;
        if (grant[SRC_MEM]) begin
            grant_reg  = mem_reg;
            grant_data = mem_data;
        end
    end

    // Round-robin pointer register; starts with ALU priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
            ptr_q <= PTR_ALU;
        end else begin
            ptr_q <= ptr_next;
        end
    end

    // Write stage: a grant becomes a one-cycle write strobe; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_en  <= 1'b0;
            rf_wreg      <= '0;
            rf_writedata <= '0;
        end else begin
            rf_write_en <= any_grant;
            if (any_grant) begin
                rf_wreg      <= grant_reg;
                rf_writedata <= grant_data;
            end
        end
    end

    // Scoreboard update: commit clears, issue sets, and the set is applied last so it wins.
    always_comb begin
        busy_next = busy;
        if (rf_write_en) begin
            busy_next[rf_wreg] = 1'b0;
        end
        if (issue_en) begin
            busy_next[issue_reg] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the scoreboard is a small flop vector, so it is reset as a whole; a RAM would not be.
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // A writeback is stray when its register is neither pending nor being committed this edge.
    assign clear_same_reg = rf_write_en && (rf_wreg == grant_reg);
    assign err_hit        = any_grant && !busy[grant_reg] && !clear_same_reg;

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_err <= 1'b0;
        end else if (err_hit) begin
            wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a table of directed vectors
// plus hand-written sequences for contention, hold and asynchronous reset.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [2:0]  alu_reg;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [2:0]  mem_reg;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        issue_en;
    logic [2:0]  issue_reg;
    logic        wb_hold;
    logic        rf_write_en;
    logic [2:0]  rf_wreg;
    logic [15:0] rf_writedata;
    logic [7:0]  busy;
    logic        wb_err;

    int passed = 0;
    int total  = 0;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_reg      (alu_reg),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_reg      (mem_reg),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .issue_en     (issue_en),
        .issue_reg    (issue_reg),
        .wb_hold      (wb_hold),
        .rf_write_en  (rf_write_en),
        .rf_wreg      (rf_wreg),
        .rf_writedata (rf_writedata),
        .busy         (busy),
        .wb_err       (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [2:0]  ar;
        logic [15:0] ad;
        logic        mv;
        logic [2:0]  mr;
        logic [15:0] md;
        logic        ie;
        logic [2:0]  ir;
        logic        hold;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [2:0]  e_wreg;
        logic [15:0] e_wd;
        logic [7:0]  e_busy;
        logic        e_err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic av, input logic [2:0] ar, input logic [15:0] ad,
        input logic mv, input logic [2:0] mr, input logic [15:0] md,
        input logic ie, input logic [2:0] ir, input logic hold,
        input logic e_ar, input logic e_mr, input logic e_we,
        input logic [2:0] e_wreg, input logic [15:0] e_wd,
        input logic [7:0] e_busy, input logic e_err);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad;
        v.mv = mv; v.mr = mr; v.md = md;
        v.ie = ie; v.ir = ir; v.hold = hold;
        v.e_ar = e_ar; v.e_mr = e_mr; v.e_we = e_we;
        v.e_wreg = e_wreg; v.e_wd = e_wd; v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    task automatic drive_idle();
        alu_valid = 1'b0; alu_reg = 3'd0; alu_data = 16'h0;
        mem_valid = 1'b0; mem_reg = 3'd0; mem_data = 16'h0;
        issue_en  = 1'b0; issue_reg = 3'd0; wb_hold = 1'b0;
    endtask

    task automatic check_regs(input string tag, input logic we, input logic [2:0] wreg,
                              input logic [15:0] wd, input logic [7:0] bsy, input logic err);
        check({tag, ".rf_write_en"},  32'(rf_write_en),  32'(we));
        check({tag, ".rf_wreg"},      32'(rf_wreg),      32'(wreg));
        check({tag, ".rf_writedata"}, 32'(rf_writedata), 32'(wd));
        check({tag, ".busy"},         32'(busy),         32'(bsy));
        check({tag, ".wb_err"},       32'(wb_err),       32'(err));
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;

        // Table: starts right after a reset (pointer = ALU, busy = 0).
        //           av ar  ad       mv mr  md       ie ir  hd  ear emr we wreg wd       busy   err
        vecs[0]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h02, 0);
        vecs[1]  = mk(1, 1, 16'h0002, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 1, 1, 16'h0002, 8'h02, 0);
        vecs[2]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 16'h0002, 8'h00, 0);
        vecs[3]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2, 0, 0, 0, 0, 1, 16'h0002, 8'h04, 0);
        vecs[4]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 3, 0, 0, 0, 0, 1, 16'h0002, 8'h0C, 0);
        vecs[5]  = mk(1, 2, 16'h1111, 1, 3, 16'h2222, 0, 0, 0, 0, 1, 1, 3, 16'h2222, 8'h0C, 0);
        vecs[6]  = mk(1, 2, 16'h1111, 1, 3, 16'h2222, 0, 0, 0, 1, 0, 1, 2, 16'h1111, 8'h04, 0);
        vecs[7]  = mk(1, 2, 16'h1111, 1, 3, 16'h2222, 1, 3, 1, 0, 0, 0, 2, 16'h1111, 8'h08, 0);
        vecs[8]  = mk(1, 2, 16'h1111, 1, 3, 16'h2222, 0, 0, 0, 0, 1, 1, 3, 16'h2222, 8'h08, 0);
        vecs[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 3, 0, 0, 0, 0, 3, 16'h2222, 8'h08, 0);
        vecs[10] = mk(1, 3, 16'h3333, 0, 0, 16'h0000, 1, 4, 0, 1, 0, 1, 3, 16'h3333, 8'h18, 0);
        vecs[11] = mk(0, 0, 16'h0000, 1, 4, 16'h4444, 0, 0, 0, 0, 1, 1, 4, 16'h4444, 8'h10, 0);
        vecs[12] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 4, 16'h4444, 8'h00, 0);
        vecs[13] = mk(0, 0, 16'h0000, 1, 5, 16'h5555, 0, 0, 0, 0, 1, 1, 5, 16'h5555, 8'h00, 1);
        vecs[14] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 5, 16'h5555, 8'h00, 1);

        // Reset values while reset is held.
        #12;
        check_regs("reset", 1'b0, 3'd0, 16'h0, 8'h00, 1'b0);
        check("reset.alu_ready", 32'(alu_ready), 32'd0);
        check("reset.mem_ready", 32'(mem_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention: issue regs 2 and 3, then both requesters valid continuously.
        @(negedge clk); issue_en = 1'b1; issue_reg = 3'd2;
        @(negedge clk); issue_reg = 3'd3;
        @(negedge clk);
        drive_idle();
        alu_valid = 1'b1; alu_reg = 3'd2; alu_data = 16'h1111;
        mem_valid = 1'b1; mem_reg = 3'd3; mem_data = 16'h2222;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("cont%0d.alu_ready", i), 32'(alu_ready), 32'((i % 2) == 0));
            check($sformatf("cont%0d.mem_ready", i), 32'(mem_ready), 32'((i % 2) == 1));
            @(posedge clk); #1;
            check($sformatf("cont%0d.rf_write_en", i), 32'(rf_write_en), 32'd1);
            check($sformatf("cont%0d.rf_wreg", i), 32'(rf_wreg), ((i % 2) == 0) ? 32'd2 : 32'd3);
            @(negedge clk);
        end

        // Hold for three cycles with both valid: no grants, write strobe drops.
        wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("hold%0d.alu_ready", i), 32'(alu_ready), 32'd0);
            check($sformatf("hold%0d.mem_ready", i), 32'(mem_ready), 32'd0);
            @(posedge clk); #1;
            check($sformatf("hold%0d.rf_write_en", i), 32'(rf_write_en), 32'd0);
            @(negedge clk);
        end
        // Release: after six alternating grants the pointer is back on ALU.
        wb_hold = 1'b0;
        #1;
        check("release.alu_ready", 32'(alu_ready), 32'd1);
        check("release.mem_ready", 32'(mem_ready), 32'd0);
        @(posedge clk); #1;
        check("release.rf_write_en", 32'(rf_write_en), 32'd1);
        check("release.rf_wreg", 32'(rf_wreg), 32'd2);
        check("cont.wb_err", 32'(wb_err), 32'd1);

        // Mid-cycle asynchronous reset drops the in-flight write and clears the error.
        #2;
        drive_idle();
        rst_n = 1'b0;
        #1;
        check_regs("async_rst", 1'b0, 3'd0, 16'h0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        alu_valid = 1'b1; alu_reg = 3'd0; alu_data = 16'hABCD;
        #1;
        check("post_rst.alu_ready", 32'(alu_ready), 32'd1);
        check("post_rst.mem_ready", 32'(mem_ready), 32'd0);

        // Table-driven vectors from a clean reset.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            alu_valid = vecs[i].av; alu_reg = vecs[i].ar; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_reg = vecs[i].mr; mem_data = vecs[i].md;
            issue_en  = vecs[i].ie; issue_reg = vecs[i].ir; wb_hold = vecs[i].hold;
            #1;
            check($sformatf("vec%0d.alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ar));
            check($sformatf("vec%0d.mem_ready", i), 32'(mem_ready), 32'(vecs[i].e_mr));
            @(posedge clk); #1;
            check_regs($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_wreg,
                       vecs[i].e_wd, vecs[i].e_busy, vecs[i].e_err);
            @(negedge clk);
        end

        // Sticky error survives idle cycles and clears only on reset.
        drive_idle();
        repeat (2) @(negedge clk);
        check("err_sticky.wb_err", 32'(wb_err), 32'd1);
        rst_n = 1'b0;
        #1;
        check("err_reset.wb_err", 32'(wb_err), 32'd0);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
